axis_frame_marker: RTL and testbench
====================================

// Module: axis_frame_marker
// PURPOSE
//   Parametrised AXI-Stream framer: tags a raw sample stream with tuser (first beat of frame) and tlast
//   (last beat), for CH time-interleaved channels and a runtime frame length. Sits between ADC/source
//   streams and the FFT/spectrum pipeline; replaces bench-side index counters with synthesizable framing.
//   Adds run/drain control, resync and a registered output stage.
// PARAMETERS
//   DW       16    tdata width
//   CH       1     interleaved channels per time step (>=1); beat order ch0..ch(CH-1)
//   LEN_MAX  1024  maximum frame length in time steps
//   LW       $clog2(LEN_MAX+1)  width of frame_len
//   CW       $clog2(CH) (min 1) width of channel tag
// PORTS
//   clk        in   1    clock
//   reset_n    in   1    async active-low reset
//   ce         in   1    clock enable; 0 freezes all state, tready_s=0
//   en         in   1    run request
//   resync     in   1    pulse: abort current frame, next accepted beat starts a new frame
//   frame_len  in   LW   time steps per frame; sampled at each frame start
//   tdata_s    in   DW   input sample
//   tvalid_s   in   1    input valid
//   tready_s   out  1    input ready
//   tdata_m    out  DW   output sample
//   tuser_m    out  1    first beat of frame
//   tlast_m    out  1    last beat of frame
//   tid_m      out  CW   channel of beat
//   tvalid_m   out  1    output valid
//   tready_m   in   1    output ready
//   busy       out  1    state != IDLE
// BEHAVIOUR
//   - Reset: state=IDLE, idx=0, ch=0, all outputs 0 (tvalid_m/tuser_m/tlast_m/tid_m/tdata_m/busy/tready_s).
//   - Output is one register stage: beat accepted at edge N appears on tdata_m after edge N; latency 1.
//     tready_s = ce && state!=IDLE && (!tvalid_m || tready_m); full throughput, no bubbles.
//   - Output holds stable while tvalid_m && !tready_m (AXI rule); tvalid_m never drops without transfer.
//   - Counters advance only on input transfer (tvalid_s && tready_s): ch++ ; on ch==CH-1, ch=0, idx++;
//     on idx==len-1 && ch==CH-1 -> tlast, idx=0, ch=0.
//   - tuser = (idx==0 && ch==0); tlast = (idx==len-1 && ch==CH-1); len=1,CH=1 gives both on same beat.
//   - len latched from frame_len when a frame starts (first beat, idx==0,ch==0). frame_len==0 or >LEN_MAX
//     -> len=LEN_MAX. Mid-frame frame_len changes ignored.
//   - FSM: IDLE --en--> RUN; RUN --!en && idx==0 && ch==0--> IDLE; RUN --!en mid-frame--> DRAIN;
//     DRAIN: keeps accepting until tlast beat transferred in, then IDLE; en re-asserted in DRAIN -> RUN.
//     Output register still drains to tready_m in IDLE.
//   - resync (RUN/DRAIN/IDLE): idx=0, ch=0 next edge; beat transferring that same cycle is emitted with
//     tlast=1 (truncated frame end). resync has priority over counter advance. In DRAIN -> IDLE.
//   - ce=0: no state/output change; tvalid_m held; resync/en ignored.
//   - reset_n low mid-frame: immediate clear; pending output beat discarded.
// CONFIGURATION
//   AXIS_FRAME_MARKER_STATS_EN defined: adds ports frame_cnt out 32 (completed tlast transfers on
//   output, wraps at 2^32) and trunc_cnt out 16 (resync-truncated frames, saturates at 16'hFFFF);
//   both reset to 0. Undefined: ports and counters absent; framing behaviour identical.
// TESTING
//   1 CH=1,len=1024, en=1, tvalid_s=1, tready_m=1 -> tuser_m on beats 0,1024; tlast_m on 1023,2047; no gaps.
//   2 CH=4,frame_len=8 -> 32 beats/frame, tid_m cycles 0,1,2,3; tuser beat0, tlast beat31 (tid=3).
//   3 frame_len 8->16 at beat 5 -> current frame ends at beat 7; next frame 16 long; frame_len=0 -> 1024.
//   4 en dropped at beat 3 of len=8 -> beats 4..7 still accepted, tlast on 7, then tready_s=0, busy=0.
//   5 tready_m random 50% -> tdata_m stable while stalled; output sequence equals input, no loss/dup.
//   6 resync at beat 5 of len=8 -> beat5 tlast=1, next beat tuser=1; trunc_cnt=1 with STATS_EN.

Source files
------------

// File: rtl/axis_frame_marker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// axis_frame_marker
//
// Purpose
//   AXI-Stream framer. Tags a raw sample stream with tuser_m (first beat of a
//   frame) and tlast_m (last beat of a frame). A frame is frame_len time steps
//   of CH time-interleaved channels (beat order ch0..ch(CH-1)). Includes
//   run/drain control, a resync pulse that truncates the current frame, and a
//   single registered output stage with full throughput.
//
// Parameters
//   DW       tdata width
//   CH       interleaved channels per time step (>= 1)
//   LEN_MAX  maximum frame length in time steps
//   LW       width of frame_len
//   CW       width of the channel tag (minimum 1)
//
// Ports
//   clk        in   clock
//   reset_n    in   asynchronous active-low reset
//   ce         in   clock enable; low freezes all state and forces tready_s low
//   en         in   run request
//   resync     in   pulse: abort current frame, next accepted beat starts a frame
//   frame_len  in   time steps per frame, sampled on the first beat of each frame
//   tdata_s    in   input sample
//   tvalid_s   in   input valid
//   tready_s   out  input ready
//   tdata_m    out  output sample
//   tuser_m    out  first beat of frame
//   tlast_m    out  last beat of frame
//   tid_m      out  channel of the beat
//   tvalid_m   out  output valid
//   tready_m   in   output ready
//   busy       out  framer is not idle
//
// Optional feature (macro AXIS_FRAME_MARKER_STATS_EN)
//   frame_cnt  out  32-bit count of tlast transfers on the output (wraps)
//   trunc_cnt  out  16-bit count of frames truncated by resync (saturates)
// -----------------------------------------------------------------------------
module axis_frame_marker #(
  parameter int DW      = 16,
  parameter int CH      = 1,
  parameter int LEN_MAX = 1024,
  parameter int LW      = $clog2(LEN_MAX + 1),
  parameter int CW      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic          en,
  input  logic          resync,
  input  logic [LW-1:0] frame_len,
  input  logic [DW-1:0] tdata_s,
  input  logic          tvalid_s,
  output logic          tready_s,
  output logic [DW-1:0] tdata_m,
  output logic          tuser_m,
  output logic          tlast_m,
  output logic [CW-1:0] tid_m,
  output logic          tvalid_m,
  input  logic          tready_m,
  output logic          busy
`ifdef AXIS_FRAME_MARKER_STATS_EN
  ,
  output logic [31:0]   frame_cnt,
  output logic [15:0]   trunc_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [LW-1:0] LEN_MAX_L = LW'(LEN_MAX);
  localparam logic [CW-1:0] CH_LAST_L = CW'(CH - 1);
  localparam logic [LW-1:0] IDX_ONE_L = LW'(1'b1);
  localparam logic [CW-1:0] CH_ONE_L  = CW'(1'b1);

  // Out-of-range requests (zero or above LEN_MAX) fall back to LEN_MAX.
  function automatic logic [LW-1:0] sanitize_len(input logic [LW-1:0] fl);
    logic [LW-1:0] res;
    if ((fl == {LW{1'b0}}) || (fl > LEN_MAX_L)) begin
      res = LEN_MAX_L;
    end else begin
      res = fl;
    end
    return res;
  endfunction

  state_t          state_q;
  logic [LW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [LW-1:0]   len_q, len_d;

  logic [DW-1:0]   tdata_q;
  logic            tuser_q;
  logic            tlast_q;
  logic [CW-1:0]   tid_q;
  logic            tvalid_q;

  logic [LW-1:0]   len_sane_s;
  logic [LW-1:0]   len_eff_s;
  logic [LW-1:0]   len_last_s;
  logic            frame_start_s;
  logic            ch_last_s;
  logic            idx_last_s;
  logic            nat_last_s;
  logic            xfer_s;
  logic            out_xfer_s;
  logic            bound_next_s;

  // Input handshake: accept only while running/draining and the output
  // register is empty or being emptied this cycle.
  assign tready_s   = ce && (state_q != ST_IDLE) && (!tvalid_q || tready_m);
  assign xfer_s     = tvalid_s && tready_s;
  assign out_xfer_s = ce && tvalid_q && tready_m;

  // Frame position decode for the beat currently offered at the input.
  always_comb begin
    len_sane_s    = sanitize_len(frame_len);
    frame_start_s = (idx_q == {LW{1'b0}}) && (ch_q == {CW{1'b0}});
    // The first beat of a frame must already see the new length, otherwise a
    // one-step frame could never flag tlast on its only time step.
    if (frame_start_s) begin
      len_eff_s = len_sane_s;
    end else begin
      len_eff_s = len_q;
    end
    len_last_s = len_eff_s - IDX_ONE_L;
    ch_last_s  = (ch_q == CH_LAST_L);
    idx_last_s = (idx_q == len_last_s);
    nat_last_s = ch_last_s && idx_last_s;
  end

  // Next-state of the frame counters; resync wins over a counter advance.
  always_comb begin
    idx_d = idx_q;
    ch_d  = ch_q;
    len_d = len_q;
    if (resync) begin
      idx_d = {LW{1'b0}};
      ch_d  = {CW{1'b0}};
    end else if (xfer_s) begin
      if (ch_last_s) begin
        ch_d = {CW{1'b0}};
        if (idx_last_s) begin
          idx_d = {LW{1'b0}};
        end else begin
          idx_d = idx_q + IDX_ONE_L;
        end
      end else begin
        ch_d  = ch_q + CH_ONE_L;
        idx_d = idx_q;
      end
    end else begin
      idx_d = idx_q;
      ch_d  = ch_q;
    end
    if (xfer_s && frame_start_s) begin
      len_d = len_sane_s;
    end else begin
      len_d = len_q;
    end
    bound_next_s = (idx_d == {LW{1'b0}}) && (ch_d == {CW{1'b0}});
  end

  // Run/drain control. Leaving RUN looks at the post-update counters so a beat
  // that starts a frame in the same cycle en falls still gets drained.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else if (ce) begin
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!en && bound_next_s) begin
            state_q <= ST_IDLE;
          end else if (!en) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (resync) begin
            state_q <= ST_IDLE;
          end else if (en) begin
            state_q <= ST_RUN;
          end else if (bound_next_s) begin
            // Only reachable here by transferring the natural tlast beat.
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Frame counters and latched frame length.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= {LW{1'b0}};
      ch_q  <= {CW{1'b0}};
      len_q <= LEN_MAX_L;
    end else if (ce) begin
      idx_q <= idx_d;
      ch_q  <= ch_d;
      len_q <= len_d;
    end
  end

  // Output register stage: load on input transfer, empty on downstream accept,
  // otherwise hold everything stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tdata_q  <= {DW{1'b0}};
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      tid_q    <= {CW{1'b0}};
      tvalid_q <= 1'b0;
    end else if (ce) begin
      if (xfer_s) begin
        tdata_q  <= tdata_s;
        tuser_q  <= frame_start_s;
        tlast_q  <= nat_last_s || resync;
        tid_q    <= ch_q;
        tvalid_q <= 1'b1;
      end else if (tready_m) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign tdata_m  = tdata_q;
  assign tuser_m  = tuser_q;
  assign tlast_m  = tlast_q;
  assign tid_m    = tid_q;
  assign tvalid_m = tvalid_q;
  assign busy     = (state_q != ST_IDLE);

`ifdef AXIS_FRAME_MARKER_STATS_EN
  logic [31:0] frame_cnt_q;
  logic [15:0] trunc_cnt_q;
  logic        trunc_ev_s;

  // A resync truncates a frame when it lands mid-frame, or when the beat it
  // tags would not have been the natural last beat anyway.
  always_comb begin
    if (resync) begin
      if (xfer_s) begin
        trunc_ev_s = !nat_last_s;
      end else begin
        trunc_ev_s = !frame_start_s;
      end
    end else begin
      trunc_ev_s = 1'b0;
    end
  end

  // Statistics counters: frames leave on tlast transfers, truncations saturate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= 32'd0;
      trunc_cnt_q <= 16'd0;
    end else if (ce) begin
      if (out_xfer_s && tlast_q) begin
        frame_cnt_q <= frame_cnt_q + 32'd1;
      end
      if (trunc_ev_s && (trunc_cnt_q != 16'hFFFF)) begin
        trunc_cnt_q <= trunc_cnt_q + 16'd1;
      end
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign trunc_cnt = trunc_cnt_q;
`endif

endmodule

// File: tb/tb_axis_frame_marker.sv
`timescale 1ns/1ps
// Testbench for axis_frame_marker: two instances (CH=1 and CH=4) driven from
// one cycle task; a beat-position reference model predicts every output beat.
module tb_axis_frame_marker;

  localparam int DW      = 16;
  localparam int LEN_MAX = 1024;
  localparam int LW      = $clog2(LEN_MAX + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset_n;
  logic [1:0]          ce_a, en_a, resync_a, tvalid_s_a, tready_m_a;
  logic [LW-1:0]       frame_len_a [2];
  logic [DW-1:0]       tdata_s_a   [2];

  wire  [1:0]          tready_s_w, tuser_w, tlast_w, tvalid_w, busy_w;
  wire  [DW-1:0]       tdata_w [2];
  wire                 tid0_w;
  wire  [1:0]          tid1_w;
  wire  [1:0]          tid_a [2];
  assign tid_a[0] = {1'b0, tid0_w};
  assign tid_a[1] = tid1_w;
`ifdef AXIS_FRAME_MARKER_STATS_EN
  wire  [31:0]         frame_cnt_w [2];
  wire  [15:0]         trunc_cnt_w [2];
`endif

  axis_frame_marker #(.DW(DW), .CH(1), .LEN_MAX(LEN_MAX)) dut_ch1 (
    .clk(clk), .reset_n(reset_n), .ce(ce_a[0]), .en(en_a[0]), .resync(resync_a[0]),
    .frame_len(frame_len_a[0]), .tdata_s(tdata_s_a[0]), .tvalid_s(tvalid_s_a[0]),
    .tready_s(tready_s_w[0]), .tdata_m(tdata_w[0]), .tuser_m(tuser_w[0]),
    .tlast_m(tlast_w[0]), .tid_m(tid0_w), .tvalid_m(tvalid_w[0]),
    .tready_m(tready_m_a[0]), .busy(busy_w[0])
`ifdef AXIS_FRAME_MARKER_STATS_EN
    , .frame_cnt(frame_cnt_w[0]), .trunc_cnt(trunc_cnt_w[0])
`endif
  );

  axis_frame_marker #(.DW(DW), .CH(4), .LEN_MAX(LEN_MAX)) dut_ch4 (
    .clk(clk), .reset_n(reset_n), .ce(ce_a[1]), .en(en_a[1]), .resync(resync_a[1]),
    .frame_len(frame_len_a[1]), .tdata_s(tdata_s_a[1]), .tvalid_s(tvalid_s_a[1]),
    .tready_s(tready_s_w[1]), .tdata_m(tdata_w[1]), .tuser_m(tuser_w[1]),
    .tlast_m(tlast_w[1]), .tid_m(tid1_w), .tvalid_m(tvalid_w[1]),
    .tready_m(tready_m_a[1]), .busy(busy_w[1])
`ifdef AXIS_FRAME_MARKER_STATS_EN
    , .frame_cnt(frame_cnt_w[1]), .trunc_cnt(trunc_cnt_w[1])
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: beat position inside the current frame, frame size in
  // beats, and expected output beats {tdata, tuser, tlast, tid}.
  logic [DW+3:0] exp_q0 [$];
  logic [DW+3:0] exp_q1 [$];
  int            pos         [2];
  int            frame_beats [2];
  int            exp_frames  [2];
  int            exp_trunc   [2];
  bit            acc_now     [2];
  bit            hold_p      [2];
  logic [DW+4:0] held        [2];

  function automatic int ch_of(input int u);
    return (u == 0) ? 1 : 4;
  endfunction

  function automatic int sane_len(input logic [LW-1:0] fl);
    if (fl == 0 || int'(fl) > LEN_MAX) return LEN_MAX;
    return int'(fl);
  endfunction

  task automatic model_clear();
    exp_q0.delete();
    exp_q1.delete();
    for (int u = 0; u < 2; u++) begin
      pos[u] = 0; frame_beats[u] = 0; exp_frames[u] = 0;
      exp_trunc[u] = 0; acc_now[u] = 1'b0; hold_p[u] = 1'b0;
    end
  endtask

  // One clock cycle: sample at negedge+1, check outputs, update the model,
  // then advance to the next negedge where inputs may change.
  task automatic tick();
    logic [DW+3:0] obs;
    logic [DW+3:0] expv;
    logic [DW+4:0] cur;
    logic [1:0]    tid_e;
    bit            nat_last;
    bit            empty;
    #1;
    for (int u = 0; u < 2; u++) begin
      obs = {tdata_w[u], tuser_w[u], tlast_w[u], tid_a[u]};
      cur = {tvalid_w[u], obs};
      if (hold_p[u]) begin
        checks++;
        if (cur !== held[u]) begin
          errors++;
          $display("FAIL hold_stable u%0d got %h want %h", u, cur, held[u]);
        end
      end
      hold_p[u] = tvalid_w[u] && (!tready_m_a[u] || !ce_a[u]);
      held[u]   = cur;

      if (ce_a[u] && tvalid_w[u] && tready_m_a[u]) begin
        checks++;
        empty = (u == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
        if (empty) begin
          errors++;
          $display("FAIL spurious_beat u%0d got %h want none", u, obs);
        end else begin
          expv = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          if (obs !== expv) begin
            errors++;
            $display("FAIL out_beat u%0d got %h want %h (data,user,last,tid)", u, obs, expv);
          end
          if (expv[2]) exp_frames[u]++;
        end
      end

      acc_now[u] = ce_a[u] && tvalid_s_a[u] && tready_s_w[u];
      if (ce_a[u]) begin
        if (acc_now[u]) begin
          if (pos[u] == 0) frame_beats[u] = sane_len(frame_len_a[u]) * ch_of(u);
          nat_last = (pos[u] == frame_beats[u] - 1);
          tid_e    = 2'(pos[u] % ch_of(u));
          expv     = {tdata_s_a[u], (pos[u] == 0), (nat_last || resync_a[u]), tid_e};
          if (u == 0) exp_q0.push_back(expv); else exp_q1.push_back(expv);
          if (resync_a[u] && !nat_last) exp_trunc[u]++;
          pos[u] = (nat_last || resync_a[u]) ? 0 : pos[u] + 1;
        end else if (resync_a[u]) begin
          if (pos[u] != 0) exp_trunc[u]++;
          pos[u] = 0;
        end
      end
    end
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      if (acc_now[u]) tdata_s_a[u] = DW'($urandom);
    end
  endtask

  // Offer beats on unit u until n are accepted (bounded).
  task automatic stream_n(input int u, input int n, output int used);
    int got;
    got  = 0;
    used = 0;
    tvalid_s_a[u] = 1'b1;
    while (got < n && used < n * 6 + 40) begin
      tick();
      used++;
      if (acc_now[u]) got++;
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL stream_accept u%0d got %0d want %0d", u, got, n);
    end
  endtask

  task automatic drain();
    tvalid_s_a = 2'b00; tready_m_a = 2'b11; ce_a = 2'b11; resync_a = 2'b00;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL drain_empty got %0d/%0d pending want 0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic realign(input int u);
    tvalid_s_a[u] = 1'b0;
    resync_a[u]   = 1'b1;
    tick();
    resync_a[u]   = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW+6:0] o;
    reset_n = 1'b0; ce_a = 2'b11; en_a = 2'b11; tvalid_s_a = 2'b11; tready_m_a = 2'b11;
    tick(); tick();
    for (int u = 0; u < 2; u++) begin
      o = {tvalid_w[u], tuser_w[u], tlast_w[u], tid_a[u], tdata_w[u], busy_w[u], tready_s_w[u]};
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL reset_outputs u%0d got %h want 0", u, o);
      end
    end
    en_a = 2'b00; tvalid_s_a = 2'b00;
    reset_n = 1'b1;
    tick(); tick();
    checks++;
    if (busy_w !== 2'b00) begin
      errors++;
      $display("FAIL idle_busy got %b want 00", busy_w);
    end
  endtask

  task automatic test_long_frames();
    int used, f0;
    f0 = exp_frames[0];
    en_a[0] = 1'b1; frame_len_a[0] = 11'd1024; tready_m_a[0] = 1'b1;
    stream_n(0, 2048, used);
    checks++;
    if (used != 2049) begin
      errors++;
      $display("FAIL no_gaps cycles %0d want 2049", used);
    end
    drain();
    checks++;
    if (exp_frames[0] - f0 != 2) begin
      errors++;
      $display("FAIL long_frames tlast_count got %0d want 2", exp_frames[0] - f0);
    end
  endtask

  task automatic test_channels();
    int used, f1;
    en_a[1] = 1'b1; frame_len_a[1] = 11'd8; tready_m_a[1] = 1'b1;
    realign(1);
    f1 = exp_frames[1];
    stream_n(1, 64, used);
    drain();
    checks++;
    if (exp_frames[1] - f1 != 2) begin
      errors++;
      $display("FAIL ch4_frames got %0d want 2", exp_frames[1] - f1);
    end
  endtask

  task automatic test_len_change();
    int used, f0;
    en_a[0] = 1'b1; frame_len_a[0] = 11'd8; tready_m_a[0] = 1'b1;
    realign(0);
    f0 = exp_frames[0];
    stream_n(0, 5, used);
    frame_len_a[0] = 11'd16;
    stream_n(0, 3 + 16, used);
    frame_len_a[0] = 11'd0;
    stream_n(0, 1024, used);
    frame_len_a[0] = 11'd1500;
    stream_n(0, 1024, used);
    drain();
    checks++;
    if (exp_frames[0] - f0 != 4) begin
      errors++;
      $display("FAIL len_change_frames got %0d want 4", exp_frames[0] - f0);
    end
  endtask

  task automatic test_drain();
    int used, acc;
    en_a[0] = 1'b1; frame_len_a[0] = 11'd8; tready_m_a[0] = 1'b1;
    realign(0);
    stream_n(0, 4, used);
    en_a[0] = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc_now[0]) acc++;
      if (i == 1) begin
        checks++;
        if (busy_w[0] !== 1'b1) begin
          errors++;
          $display("FAIL drain_busy got %b want 1", busy_w[0]);
        end
      end
    end
    checks++;
    if (acc != 4) begin
      errors++;
      $display("FAIL drain_beats got %0d want 4", acc);
    end
    checks++;
    if ({busy_w[0], tready_s_w[0]} !== 2'b00) begin
      errors++;
      $display("FAIL drain_idle busy/tready got %b want 00", {busy_w[0], tready_s_w[0]});
    end
    drain();
  endtask

  task automatic test_resync();
    int used;
    en_a[0] = 1'b1; frame_len_a[0] = 11'd8; tready_m_a[0] = 1'b1;
    realign(0);
    stream_n(0, 5, used);
    resync_a[0] = 1'b1;
    tick();
    resync_a[0] = 1'b0;
    checks++;
    if (acc_now[0] !== 1'b1) begin
      errors++;
      $display("FAIL resync_accept got %b want 1", acc_now[0]);
    end
    stream_n(0, 3, used);
    drain();
`ifdef AXIS_FRAME_MARKER_STATS_EN
    checks++;
    if (trunc_cnt_w[0] !== 16'(exp_trunc[0])) begin
      errors++;
      $display("FAIL trunc_cnt got %0d want %0d", trunc_cnt_w[0], exp_trunc[0]);
    end
`endif
  endtask

  task automatic test_midreset();
    int used;
    en_a[1] = 1'b1; frame_len_a[1] = 11'd8; tready_m_a[1] = 1'b1;
    realign(1);
    stream_n(1, 10, used);
    tready_m_a[1] = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({tvalid_w[1], busy_w[1]} !== 2'b00) begin
      errors++;
      $display("FAIL async_reset valid/busy got %b want 00", {tvalid_w[1], busy_w[1]});
    end
    model_clear();
    tick();
    reset_n = 1'b1;
    tready_m_a[1] = 1'b1;
    stream_n(1, 40, used);
    drain();
`ifdef AXIS_FRAME_MARKER_STATS_EN
    checks++;
    if (frame_cnt_w[1] !== 32'(exp_frames[1])) begin
      errors++;
      $display("FAIL frame_cnt_after_reset got %0d want %0d", frame_cnt_w[1], exp_frames[1]);
    end
`endif
  endtask

  task automatic test_random();
    en_a = 2'b11;
    for (int i = 0; i < 1500; i++) begin
      for (int u = 0; u < 2; u++) begin
        tready_m_a[u]  = 1'($urandom_range(1, 0));
        tvalid_s_a[u]  = ($urandom_range(9, 0) < 7);
        ce_a[u]        = ($urandom_range(9, 0) != 0);
        en_a[u]        = ($urandom_range(9, 0) != 0);
        resync_a[u]    = ($urandom_range(29, 0) == 0);
        frame_len_a[u] = LW'($urandom_range(6, 1));
      end
      tick();
    end
    drain();
`ifdef AXIS_FRAME_MARKER_STATS_EN
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (frame_cnt_w[u] !== 32'(exp_frames[u]) || trunc_cnt_w[u] !== 16'(exp_trunc[u])) begin
        errors++;
        $display("FAIL stats u%0d got %0d/%0d want %0d/%0d", u, frame_cnt_w[u], trunc_cnt_w[u],
                 exp_frames[u], exp_trunc[u]);
      end
    end
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    ce_a = 2'b00; en_a = 2'b00; resync_a = 2'b00; tvalid_s_a = 2'b00; tready_m_a = 2'b00;
    for (int u = 0; u < 2; u++) begin
      frame_len_a[u] = 11'd8;
      tdata_s_a[u]   = DW'($urandom);
    end
    model_clear();
    @(negedge clk);
    test_reset();
    test_long_frames();
    test_channels();
    test_len_change();
    test_drain();
    test_resync();
    test_midreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
